// File: rtl/amstrad_mem_arbiter.sv
// amstrad_mem_arbiter: shares one 16-bit req/ack memory port between the Z80 bus and the video fetcher.
// Latency: request to mem_req is 1 cycle; mem_ack to cpu_done/vid_valid is 1 cycle, then 1 turnaround cycle.
// Backpressure: CPU held via cpu_busy until cpu_done; video is one-deep, a lost request sets sticky vid_overrun.
// Optional refresh generator: define AMSTRAD_MEM_ARB_REFRESH_EN.
module amstrad_mem_arbiter #(
    parameter logic [6:0] VID_BANK       = 7'h00,
    parameter int         VID_BURST      = 2,
    parameter int         REFRESH_PERIOD = 64
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        cpu_rd_i,
    input  logic        cpu_wr_i,
    input  logic [22:0] cpu_addr_i,
    input  logic [7:0]  cpu_wdata_i,
    output logic [7:0]  cpu_rdata_o,
    output logic        cpu_busy_o,
    output logic        cpu_done_o,
    input  logic        vid_req_i,
    input  logic [14:0] vid_addr_i,
    output logic [15:0] vid_data_o,
    output logic        vid_valid_o,
    output logic        vid_overrun_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [1:0]  mem_be_o,
    output logic [22:0] mem_addr_o,
    output logic [15:0] mem_wdata_o,
    input  logic [15:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        mem_refresh_o
);

    localparam logic [3:0] BURST_LIM = 4'(VID_BURST);
    localparam logic [7:0] REF_LAST  = 8'(REFRESH_PERIOD - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_VID  = 3'd1,
        ST_CPU  = 3'd2,
        ST_DONE = 3'd3
`ifdef AMSTRAD_MEM_ARB_REFRESH_EN
        , ST_REF = 3'd4
`endif
    } state_t;

    state_t      state_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [1:0]  mem_be_q;
    logic [22:0] mem_addr_q;
    logic [15:0] mem_wdata_q;
    logic        mem_refresh_q;
    logic [7:0]  cpu_rdata_q;
    logic        cpu_done_q;
    logic        cpu_busy_q;
    logic        cpu_seen_q;
    logic [15:0] vid_data_q;
    logic        vid_valid_q;
    logic        vid_overrun_q;
    logic        vid_pend_q;
    logic [14:0] vid_addr_q;
    logic [3:0]  vid_cnt_q;

    logic        cpu_req;
    logic        cpu_pend;
    logic        cpu_seen_d;
    logic        vid_want;
    logic        vid_blocked;
    logic [14:0] vid_sel_addr;
    logic [3:0]  vid_cnt_d;
    logic        in_idle;
    logic        ack_now;
    logic        grant_vid;
    logic        grant_ref;
    logic        grant_cpu;

    // Request decode and arbitration; fresh requests compete alongside latched ones.
    always_comb begin
        cpu_req      = cpu_rd_i | cpu_wr_i;
        // The CPU keeps its strobe up through the cpu_done cycle, so a completed
        // transaction must be masked until the strobe drops.
        cpu_pend     = cpu_req & ~cpu_seen_q;
        vid_want     = vid_req_i | vid_pend_q;
        vid_sel_addr = vid_req_i ? vid_addr_i : vid_addr_q;
        vid_blocked  = (vid_cnt_q == BURST_LIM) && cpu_pend;
        in_idle      = (state_q == ST_IDLE);
        ack_now      = mem_req_q & mem_ack_i;
        grant_vid    = in_idle && vid_want && !vid_blocked;
        grant_cpu    = in_idle && cpu_pend && !grant_vid && !grant_ref;
        cpu_seen_d   = cpu_req & (cpu_seen_q | (ack_now && (state_q == ST_CPU)));
        vid_cnt_d    = vid_cnt_q;
        if (!cpu_pend || grant_cpu) begin
            vid_cnt_d = 4'd0;
        end else if (grant_vid) begin
            vid_cnt_d = vid_cnt_q + 4'd1;
        end
    end

`ifdef AMSTRAD_MEM_ARB_REFRESH_EN
    logic [7:0] ref_cnt_q;
    logic       ref_pend_q;
    logic       ref_expire;

    assign ref_expire = (ref_cnt_q == REF_LAST);
    assign grant_ref  = in_idle && (ref_pend_q || ref_expire) && !grant_vid;

    // Free-running refresh timer; an expiry while one is already pending is absorbed.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ref_cnt_q  <= 8'd0;
            ref_pend_q <= 1'b0;
        end else begin
            ref_cnt_q  <= ref_expire ? 8'd0 : ref_cnt_q + 8'd1;
            ref_pend_q <= ref_expire | (ref_pend_q & ~(ack_now && (state_q == ST_REF)));
        end
    end
`else
    assign grant_ref = 1'b0;
    logic unused_refresh_cfg;
    assign unused_refresh_cfg = ^REF_LAST;
`endif

    // Pending capture for video, CPU completion tracking and the fairness counter.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            vid_pend_q    <= 1'b0;
            vid_addr_q    <= 15'd0;
            vid_overrun_q <= 1'b0;
            vid_cnt_q     <= 4'd0;
            cpu_seen_q    <= 1'b0;
            cpu_busy_q    <= 1'b0;
        end else begin
            if (vid_req_i) begin
                vid_addr_q <= vid_addr_i;
                if (vid_pend_q) begin
                    vid_overrun_q <= 1'b1;
                end
            end
            // The address moves into mem_addr at grant, so the slot frees then and
            // a request arriving during the fetch queues for the next one.
            if (grant_vid) begin
                vid_pend_q <= 1'b0;
            end else if (vid_req_i) begin
                vid_pend_q <= 1'b1;
            end
            vid_cnt_q  <= vid_cnt_d;
            cpu_seen_q <= cpu_seen_d;
            cpu_busy_q <= cpu_req & ~cpu_seen_d;
        end
    end

    // Transaction FSM; every memory-side and completion output is registered here.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= ST_IDLE;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_be_q      <= 2'b00;
            mem_addr_q    <= 23'd0;
            mem_wdata_q   <= 16'd0;
            mem_refresh_q <= 1'b0;
            cpu_rdata_q   <= 8'd0;
            cpu_done_q    <= 1'b0;
            vid_data_q    <= 16'd0;
            vid_valid_q   <= 1'b0;
        end else begin
            cpu_done_q  <= 1'b0;
            vid_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_vid) begin
                        state_q       <= ST_VID;
                        mem_req_q     <= 1'b1;
                        mem_we_q      <= 1'b0;
                        mem_be_q      <= 2'b11;
                        mem_addr_q    <= {VID_BANK, vid_sel_addr, 1'b0};
                        mem_refresh_q <= 1'b0;
                    end else if (grant_ref) begin
`ifdef AMSTRAD_MEM_ARB_REFRESH_EN
                        state_q       <= ST_REF;
`endif
                        mem_req_q     <= 1'b1;
                        mem_we_q      <= 1'b0;
                        mem_be_q      <= 2'b00;
                        mem_addr_q    <= 23'd0;
                        mem_refresh_q <= 1'b1;
                    end else if (grant_cpu) begin
                        state_q       <= ST_CPU;
                        mem_req_q     <= 1'b1;
                        mem_we_q      <= cpu_wr_i;
                        mem_be_q      <= cpu_wr_i ? (cpu_addr_i[0] ? 2'b10 : 2'b01) : 2'b11;
                        mem_addr_q    <= cpu_addr_i;
                        mem_wdata_q   <= {cpu_wdata_i, cpu_wdata_i};
                        mem_refresh_q <= 1'b0;
                    end
                end
                ST_VID: begin
                    if (mem_ack_i) begin
                        state_q     <= ST_DONE;
                        mem_req_q   <= 1'b0;
                        mem_be_q    <= 2'b00;
                        vid_data_q  <= mem_rdata_i;
                        vid_valid_q <= 1'b1;
                    end
                end
                ST_CPU: begin
                    if (mem_ack_i) begin
                        state_q    <= ST_DONE;
                        mem_req_q  <= 1'b0;
                        mem_we_q   <= 1'b0;
                        mem_be_q   <= 2'b00;
                        cpu_done_q <= 1'b1;
                        if (!mem_we_q) begin
                            cpu_rdata_q <= mem_addr_q[0] ? mem_rdata_i[15:8] : mem_rdata_i[7:0];
                        end
                    end
                end
`ifdef AMSTRAD_MEM_ARB_REFRESH_EN
                ST_REF: begin
                    if (mem_ack_i) begin
                        state_q       <= ST_DONE;
                        mem_req_q     <= 1'b0;
                        mem_refresh_q <= 1'b0;
                    end
                end
`endif
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_rdata_o   = cpu_rdata_q;
    assign cpu_busy_o    = cpu_busy_q;
    assign cpu_done_o    = cpu_done_q;
    assign vid_data_o    = vid_data_q;
    assign vid_valid_o   = vid_valid_q;
    assign vid_overrun_o = vid_overrun_q;
    assign mem_req_o     = mem_req_q;
    assign mem_we_o      = mem_we_q;
    assign mem_be_o      = mem_be_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wdata_o   = mem_wdata_q;
    assign mem_refresh_o = mem_refresh_q;

endmodule

// File: tb/tb_amstrad_mem_arbiter.sv
// tb_amstrad_mem_arbiter: directed checks of arbitration, byte lanes, fairness, overrun and reset.
// Latency: not applicable.
// Backpressure: the bench plays the memory side and acks by hand.
module tb_amstrad_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        cpu_rd_i, cpu_wr_i;
    logic [22:0] cpu_addr_i;
    logic [7:0]  cpu_wdata_i;
    logic [7:0]  cpu_rdata_o;
    logic        cpu_busy_o, cpu_done_o;
    logic        vid_req_i;
    logic [14:0] vid_addr_i;
    logic [15:0] vid_data_o;
    logic        vid_valid_o, vid_overrun_o;
    logic        mem_req_o, mem_we_o;
    logic [1:0]  mem_be_o;
    logic [22:0] mem_addr_o;
    logic [15:0] mem_wdata_o;
    logic [15:0] mem_rdata_i;
    logic        mem_ack_i;
    logic        mem_refresh_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    amstrad_mem_arbiter #(
        .VID_BANK      (7'h01),
        .VID_BURST     (2),
        .REFRESH_PERIOD(64)
    ) dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .cpu_rd_i     (cpu_rd_i),
        .cpu_wr_i     (cpu_wr_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_wdata_i  (cpu_wdata_i),
        .cpu_rdata_o  (cpu_rdata_o),
        .cpu_busy_o   (cpu_busy_o),
        .cpu_done_o   (cpu_done_o),
        .vid_req_i    (vid_req_i),
        .vid_addr_i   (vid_addr_i),
        .vid_data_o   (vid_data_o),
        .vid_valid_o  (vid_valid_o),
        .vid_overrun_o(vid_overrun_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ack_i    (mem_ack_i),
        .mem_refresh_o(mem_refresh_o)
    );

    logic [71:0] all_outs;
    assign all_outs = {cpu_rdata_o, cpu_busy_o, cpu_done_o, vid_data_o, vid_valid_o, vid_overrun_o,
                       mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, mem_refresh_o};

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Advance until mem_req is seen or the budget runs out.
    task automatic wait_req(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i <= budget && !ok; i++) begin
            if (mem_req_o === 1'b1) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset();
        reset_n_i   = 1'b0;
        cpu_rd_i    = 1'b0;
        cpu_wr_i    = 1'b0;
        cpu_addr_i  = 23'd0;
        cpu_wdata_i = 8'd0;
        vid_req_i   = 1'b0;
        vid_addr_i  = 15'd0;
        mem_rdata_i = 16'd0;
        mem_ack_i   = 1'b0;
        repeat (3) tick();
        total++;
        if (all_outs !== 72'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", all_outs);
        end
        reset_n_i = 1'b1;
        repeat (2) tick();
        total++;
        if (all_outs !== 72'd0) begin
            bad++;
            $display("FAIL idle_after_reset: got %h want 0", all_outs);
        end
    endtask

    task automatic test_cpu_read();
        int dones;
        cpu_addr_i = 23'h004001;
        cpu_rd_i   = 1'b1;
        tick();
        total++;
        if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_be_o !== 2'b11 || mem_addr_o !== 23'h004001) begin
            bad++;
            $display("FAIL rd_grant: got req=%b we=%b be=%b addr=%h want 1 0 11 004001",
                     mem_req_o, mem_we_o, mem_be_o, mem_addr_o);
        end
        total++;
        if (cpu_busy_o !== 1'b1) begin
            bad++;
            $display("FAIL rd_busy: got %b want 1", cpu_busy_o);
        end
        repeat (2) tick();
        total++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 23'h004001 || cpu_done_o !== 1'b0) begin
            bad++;
            $display("FAIL rd_hold: got req=%b addr=%h done=%b want 1 004001 0", mem_req_o, mem_addr_o, cpu_done_o);
        end
        mem_rdata_i = 16'hA55A;
        mem_ack_i   = 1'b1;
        tick();
        mem_ack_i   = 1'b0;
        mem_rdata_i = 16'h0000;
        total++;
        if (cpu_done_o !== 1'b1 || cpu_rdata_o !== 8'hA5 || cpu_busy_o !== 1'b0 || mem_req_o !== 1'b0) begin
            bad++;
            $display("FAIL rd_done: got done=%b rdata=%h busy=%b req=%b want 1 a5 0 0",
                     cpu_done_o, cpu_rdata_o, cpu_busy_o, mem_req_o);
        end
        cpu_rd_i = 1'b0;
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (cpu_done_o === 1'b1) dones++;
        end
        total++;
        if (dones !== 0 || cpu_rdata_o !== 8'hA5) begin
            bad++;
            $display("FAIL rd_single_pulse: got extra_dones=%0d rdata=%h want 0 a5", dones, cpu_rdata_o);
        end
    endtask

    task automatic test_cpu_write();
        logic [22:0] addrs [2];
        logic [7:0]  wd    [2];
        logic [1:0]  bes   [2];
        addrs = '{23'h000010, 23'h000011};
        wd    = '{8'h3C, 8'hC3};
        bes   = '{2'b01, 2'b10};
        for (int k = 0; k < 2; k++) begin
            cpu_addr_i  = addrs[k];
            cpu_wdata_i = wd[k];
            cpu_wr_i    = 1'b1;
            tick();
            total++;
            if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_be_o !== bes[k] ||
                mem_wdata_o !== {wd[k], wd[k]} || mem_addr_o !== addrs[k]) begin
                bad++;
                $display("FAIL wr_lane%0d: got req=%b we=%b be=%b wdata=%h addr=%h want 1 1 %b %h %h",
                         k, mem_req_o, mem_we_o, mem_be_o, mem_wdata_o, mem_addr_o, bes[k],
                         {wd[k], wd[k]}, addrs[k]);
            end
            mem_ack_i = 1'b1;
            tick();
            mem_ack_i = 1'b0;
            total++;
            if (cpu_done_o !== 1'b1 || mem_req_o !== 1'b0 || cpu_rdata_o !== 8'hA5) begin
                bad++;
                $display("FAIL wr_done%0d: got done=%b req=%b rdata=%h want 1 0 a5",
                         k, cpu_done_o, mem_req_o, cpu_rdata_o);
            end
            cpu_wr_i = 1'b0;
            repeat (2) tick();
        end
    endtask

    task automatic test_fairness();
        bit          ok;
        bit          is_vid;
        logic [15:0] rd;
        bit          exp_vid [5];
        logic [14:0] exp_va  [5];
        logic [14:0] nxt_va  [5];
        exp_vid = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        exp_va  = '{15'h0010, 15'h0020, 15'h0000, 15'h0030, 15'h0040};
        nxt_va  = '{15'h0020, 15'h0030, 15'h0000, 15'h0040, 15'h0000};
        cpu_addr_i = 23'h000100;
        cpu_rd_i   = 1'b1;
        vid_addr_i = 15'h0010;
        vid_req_i  = 1'b1;
        tick();
        vid_req_i  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wait_req(20, ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL fair_timeout%0d: got no mem_req want mem_req", k);
            end
            is_vid = (mem_addr_o[16] === 1'b1);
            total++;
            if (is_vid !== exp_vid[k] || (exp_vid[k] && mem_addr_o !== {7'h01, exp_va[k], 1'b0})) begin
                bad++;
                $display("FAIL fair_order%0d: got vid=%b addr=%h want vid=%b addr=%h",
                         k, is_vid, mem_addr_o, exp_vid[k], {7'h01, exp_va[k], 1'b0});
            end
            if (k == 0 || k == 1 || k == 3) begin
                vid_addr_i = nxt_va[k];
                vid_req_i  = 1'b1;
                tick();
                vid_req_i  = 1'b0;
            end
            rd          = exp_vid[k] ? 16'(16'hC000 + k) : 16'h1234;
            mem_rdata_i = rd;
            mem_ack_i   = 1'b1;
            tick();
            mem_ack_i   = 1'b0;
            total++;
            if (exp_vid[k]) begin
                if (vid_valid_o !== 1'b1 || vid_data_o !== rd) begin
                    bad++;
                    $display("FAIL fair_vdata%0d: got valid=%b data=%h want 1 %h", k, vid_valid_o, vid_data_o, rd);
                end
            end else begin
                if (cpu_done_o !== 1'b1 || cpu_rdata_o !== 8'h34) begin
                    bad++;
                    $display("FAIL fair_cdata%0d: got done=%b rdata=%h want 1 34", k, cpu_done_o, cpu_rdata_o);
                end
                cpu_rd_i = 1'b0;
            end
        end
        total++;
        if (vid_overrun_o !== 1'b0) begin
            bad++;
            $display("FAIL fair_no_overrun: got %b want 0", vid_overrun_o);
        end
        repeat (3) tick();
    endtask

    task automatic test_video_overrun();
        bit ok;
        cpu_addr_i  = 23'h000020;
        cpu_wdata_i = 8'h55;
        cpu_wr_i    = 1'b1;
        tick();
        total++;
        if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1) begin
            bad++;
            $display("FAIL ovr_cpu_grant: got req=%b we=%b want 1 1", mem_req_o, mem_we_o);
        end
        vid_addr_i = 15'h1111;
        vid_req_i  = 1'b1;
        tick();
        vid_addr_i = 15'h1234;
        tick();
        vid_req_i  = 1'b0;
        total++;
        if (vid_overrun_o !== 1'b1) begin
            bad++;
            $display("FAIL ovr_flag: got %b want 1", vid_overrun_o);
        end
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        cpu_wr_i  = 1'b0;
        wait_req(20, ok);
        total++;
        if (!ok || mem_addr_o !== 23'h012468 || mem_we_o !== 1'b0 || mem_be_o !== 2'b11) begin
            bad++;
            $display("FAIL ovr_vid_addr: got ok=%b addr=%h we=%b be=%b want 1 012468 0 11",
                     ok, mem_addr_o, mem_we_o, mem_be_o);
        end
        tick();
        total++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 23'h012468) begin
            bad++;
            $display("FAIL ovr_addr_stable: got req=%b addr=%h want 1 012468", mem_req_o, mem_addr_o);
        end
        mem_rdata_i = 16'hBEEF;
        mem_ack_i   = 1'b1;
        tick();
        mem_ack_i   = 1'b0;
        total++;
        if (vid_valid_o !== 1'b1 || vid_data_o !== 16'hBEEF) begin
            bad++;
            $display("FAIL ovr_vid_data: got valid=%b data=%h want 1 beef", vid_valid_o, vid_data_o);
        end
        tick();
        total++;
        if (vid_valid_o !== 1'b0 || vid_overrun_o !== 1'b1 || vid_data_o !== 16'hBEEF) begin
            bad++;
            $display("FAIL ovr_sticky: got valid=%b overrun=%b data=%h want 0 1 beef",
                     vid_valid_o, vid_overrun_o, vid_data_o);
        end
        repeat (2) tick();
    endtask

    task automatic test_reset_mid();
        vid_addr_i = 15'h0005;
        vid_req_i  = 1'b1;
        tick();
        vid_req_i  = 1'b0;
        total++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 23'h01000A) begin
            bad++;
            $display("FAIL mid_req: got req=%b addr=%h want 1 01000a", mem_req_o, mem_addr_o);
        end
        #2;
        reset_n_i = 1'b0;
        #1;
        total++;
        if (all_outs !== 72'd0) begin
            bad++;
            $display("FAIL mid_async_reset: got %h want 0", all_outs);
        end
        tick();
        reset_n_i = 1'b1;
        tick();
        mem_rdata_i = 16'hDEAD;
        mem_ack_i   = 1'b1;
        tick();
        mem_ack_i   = 1'b0;
        total++;
        if (vid_valid_o !== 1'b0 || cpu_done_o !== 1'b0 || vid_data_o !== 16'd0 || mem_req_o !== 1'b0) begin
            bad++;
            $display("FAIL mid_stale_ack: got valid=%b done=%b data=%h req=%b want 0 0 0000 0",
                     vid_valid_o, cpu_done_o, vid_data_o, mem_req_o);
        end
        repeat (3) tick();
        total++;
        if (mem_req_o !== 1'b0) begin
            bad++;
            $display("FAIL mid_no_retry: got req=%b want 0", mem_req_o);
        end
    endtask

`ifdef AMSTRAD_MEM_ARB_REFRESH_EN
    task automatic test_refresh();
        bit ok;
        int t0;
        wait_req(200, ok);
        total++;
        if (!ok || mem_refresh_o !== 1'b1 || mem_addr_o !== 23'd0) begin
            bad++;
            $display("FAIL ref_first: got ok=%b refresh=%b addr=%h want 1 1 0", ok, mem_refresh_o, mem_addr_o);
        end
        t0 = cyc;
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        tick();
        wait_req(200, ok);
        total++;
        if (!ok || mem_refresh_o !== 1'b1 || (cyc - t0) !== 64) begin
            bad++;
            $display("FAIL ref_period: got ok=%b refresh=%b gap=%0d want 1 1 64", ok, mem_refresh_o, cyc - t0);
        end
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        tick();
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cpu_read();
        test_cpu_write();
        test_fairness();
        test_video_overrun();
        test_reset_mid();
`ifdef AMSTRAD_MEM_ARB_REFRESH_EN
        test_refresh();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
